// File: rtl/font_rom_arbiter_if.sv
// Bus bundle between the three glyph requesters, the shared font ROM and
// the arbiter.
//   en                          machine-ready enable (no new grants when low)
//   req / req_bank / req_car / req_row
//                               per-requester read request and ROM address
//   gnt / rd_valid / rd_data    grant, read-return strobe and returned glyph row
//   overrun                     sticky per-requester starvation flag
//   rom_ad / rom_car / rom_row  address presented to the ROM
//   rom_data                    ROM row data, combinational from rom_*
// The slave modport is the arbiter's view; master is the environment's view.
interface font_rom_arbiter_if;
  logic        en;
  logic [2:0]  req;
  logic [5:0]  req_bank;
  logic [11:0] req_car;
  logic [11:0] req_row;
  logic [2:0]  gnt;
  logic [2:0]  rd_valid;
  logic [7:0]  rd_data;
  logic [2:0]  overrun;
  logic [1:0]  rom_ad;
  logic [3:0]  rom_car;
  logic [3:0]  rom_row;
  logic [7:0]  rom_data;

  modport slave (
    input  en, req, req_bank, req_car, req_row, rom_data,
    output gnt, rd_valid, rd_data, overrun, rom_ad, rom_car, rom_row
  );

  modport master (
    output en, req, req_bank, req_car, req_row, rom_data,
    input  gnt, rd_valid, rd_data, overrun, rom_ad, rom_car, rom_row
  );
endinterface

// File: rtl/font_rom_arbiter.sv
// Round-robin arbiter sharing one font ROM between three glyph requesters
// (0 = hour/timer digits, 1 = date digits, 2 = symbols).
// Ports:
//   clk    pixel clock, all state changes on its rising edge
//   reset  asynchronous, active-low reset
//   bus    font_rom_arbiter_if.slave (request, grant, ROM and return signals)
// A request sampled at edge N is granted from edge N with the winner's
// address on rom_*; the ROM row is captured and returned with rd_valid one
// cycle later. The requester currently granted is skipped at the next edge,
// so a held request never wins twice in a row.
module font_rom_arbiter (
  input  logic              clk,
  input  logic              reset,
  font_rom_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;        // index of the last granted requester
  logic [2:0]      gnt_q, gnt_d;
  logic [2:0]      rd_valid_q, rd_valid_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic [1:0]      rom_ad_q, rom_ad_d;
  logic [3:0]      rom_car_q, rom_car_d;
  logic [3:0]      rom_row_q, rom_row_d;
  logic [2:0]      overrun_q, overrun_d;
  logic [2:0][1:0] wait_q, wait_d;

  logic [2:0]      eligible;
  logic [2:0][1:0] order;               // order[0] is searched first
  logic            win_found;
  logic [1:0]      win_idx;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = IDLE;
    gnt_d      = '0;
    ptr_d      = ptr_q;
    rom_ad_d   = rom_ad_q;
    rom_car_d  = rom_car_q;
    rom_row_d  = rom_row_q;
    win_found  = 1'b0;
    win_idx    = ptr_q;
    wait_d     = wait_q;
    overrun_d  = overrun_q;

    // Only in GRANT is there a current winner to exclude.
    eligible = bus.req & ((state_q == GRANT) ? ~gnt_q : 3'b111);

    case (ptr_q)
      2'd0:    order = {2'd0, 2'd2, 2'd1};
      2'd1:    order = {2'd1, 2'd0, 2'd2};
      default: order = {2'd2, 2'd1, 2'd0};
    endcase

    // Walk the search order backwards so the earliest eligible entry is the
    // last one written and therefore wins.
    for (int k = 2; k >= 0; k--) begin
      if (eligible[order[k]]) begin
        win_found = 1'b1;
        win_idx   = order[k];
      end
    end

    if (bus.en && win_found) begin
      state_d   = GRANT;
      gnt_d     = 3'b001 << win_idx;
      ptr_d     = win_idx;
      rom_ad_d  = bus.req_bank[{win_idx, 1'b0} +: 2];
      rom_car_d = bus.req_car[{win_idx, 2'b00} +: 4];
      rom_row_d = bus.req_row[{win_idx, 2'b00} +: 4];
    end

    // The ROM is addressed by rom_* during the grant cycle, so its output is
    // captured at the edge that ends that cycle.
    rd_valid_d = gnt_q;
    rd_data_d  = (|gnt_q) ? bus.rom_data : rd_data_q;

    for (int i = 0; i < 3; i++) begin
      if (!bus.req[i] || gnt_d[i]) begin
        wait_d[i] = 2'd0;
      end else if (wait_q[i] != 2'd3) begin
        wait_d[i] = wait_q[i] + 2'd1;
      end
      if (wait_d[i] == 2'd3) begin
        overrun_d[i] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd2;                 // requester 0 is searched first
      gnt_q      <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      rom_ad_q   <= '0;
      rom_car_q  <= '0;
      rom_row_q  <= '0;
      overrun_q  <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rom_ad_q   <= rom_ad_d;
      rom_car_q  <= rom_car_d;
      rom_row_q  <= rom_row_d;
      overrun_q  <= overrun_d;
      wait_q     <= wait_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rom_ad   = rom_ad_q;
  assign bus.rom_car  = rom_car_q;
  assign bus.rom_row  = rom_row_q;
  assign bus.overrun  = overrun_q;

endmodule
